risc_bus_arbiter: RTL
=====================

RISC_BUS_ARBITER -- requirements
Module: risc_bus_arbiter

Interface
REQ-001 SHALL have parameter STOP_ADDR, default 8'hAB, bus address whose write ends simulation/execution.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles (range 2..255) before an error completion.
REQ-003 i_clk input 1: single clock; all state changes on rising edge.
REQ-004 i_rstn input 1: reset, asynchronous, active-low.
REQ-005 i_mN_req input 1 (N=0 CPU, N=1 loader): request; held with its fields until o_mN_ready.
REQ-006 i_mN_write input 1: 1 = write, 0 = read.
REQ-007 i_mN_address input 8; i_mN_data input 8: address and write data.
REQ-008 o_mN_ready output 1: one-cycle completion strobe; o_mN_rdata output 8; o_mN_err output 1, valid with ready.
REQ-009 o_bus_address output 8; o_bus_data output 8; o_bus_read output 1; o_bus_write output 1: registered slave-side bus.
REQ-010 i_bus_data input 8; i_bus_ready input 1: slave read data and access-complete.
REQ-011 o_stop output 1; o_stop_code output 8: sticky stop flag and data written to STOP_ADDR.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-013 IDLE: if any req and o_stop=0, select master, latch its address/data/write, go ACCESS; else stay.
REQ-014 Arbitration SHALL be round-robin: single requester wins; both requesting -> master not granted last; last_grant resets to 1 so m0 wins first tie.
REQ-015 ACCESS: exactly one of o_bus_read/o_bus_write high, address/data stable, from first ACCESS cycle.
REQ-016 ACCESS with i_bus_ready=1: capture i_bus_data (read) into rdata, err=0, go RESP; strobes drop next cycle.
REQ-017 ACCESS cycle counter SHALL start at 0; at count TIMEOUT-1 with i_bus_ready=0 go RESP with err=1, rdata=8'hFF.
REQ-018 i_bus_ready and timeout in same cycle: ready wins, err=0.
REQ-019 RESP: pulse o_mN_ready for granted master only, one cycle, with rdata/err; then IDLE.
REQ-020 Latency: req sampled in IDLE at edge N -> bus strobe cycle N+1 -> with immediate ready, o_mN_ready in cycle N+2; minimum 3 cycles per transfer, back-to-back.
REQ-021 Write completed (ready, not timeout) to STOP_ADDR: set o_stop=1, o_stop_code=write data, in RESP cycle; sticky.
REQ-022 o_stop=1: no further grants; pending requests never receive ready; only reset clears.
REQ-023 Read of STOP_ADDR SHALL not affect o_stop.
REQ-024 Requester deasserting req mid-transfer is a protocol violation; transfer SHALL still complete to it.
REQ-025 Ungranted master outputs: ready=0, err=0; rdata holds last value.

Reset
REQ-026 On i_rstn=0, immediately: state IDLE, counter 0, last_grant 1, all o_bus_* 0, o_mN_ready/err 0, o_mN_rdata 0, o_stop 0, o_stop_code 0.
REQ-027 Reset mid-ACCESS SHALL abort the transfer with no ready strobe; strobes drop asynchronously.
REQ-028 Release SHALL allow a grant decision at the first rising edge after deassertion.

Structure
REQ-029 Shared package risc_bus_pkg SHALL hold state enum (IDLE/ACCESS/RESP), bus width 8, default STOP_ADDR and TIMEOUT.
REQ-030 Single module; round-robin selector MAY be sub-module risc_rr_arb2; no other sub-modules.

Verification
REQ-031 m0 read 8'h10, slave ready in first ACCESS cycle with 8'h5A -> o_m0_ready at N+2, rdata 8'h5A, err 0.
REQ-032 m0 and m1 request simultaneously after reset, both held -> m0 served first, then m1, then m0; no gap beyond one IDLE cycle.
REQ-033 m1 write 8'h20, i_bus_ready held 0 -> after 16 ACCESS cycles o_m1_ready, err 1, rdata 8'hFF.
REQ-034 m0 write 8'h42 to 8'hAB, ready -> o_stop 1, o_stop_code 8'h42; subsequent m1 request gets no strobe for 50 cycles.
REQ-035 i_rstn low during ACCESS of m0 read -> bus strobes 0 immediately, no o_m0_ready; after release, held request re-granted and completes.
REQ-036 ready and timeout coincide at ACCESS cycle 15 with data 8'h33 -> err 0, rdata 8'h33.

Source files
------------

// File: rtl/risc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_bus_pkg
// Description : Shared types and constants for the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_bus_pkg;

    localparam int         c_BUS_W         = 8;
    localparam int         c_CNT_W         = 8;
    localparam logic [7:0] c_STOP_ADDR_DEF = 8'hAB;
    localparam int         c_TIMEOUT_DEF   = 16;
    localparam logic [7:0] c_ERR_RDATA     = 8'hFF;

    // Arbiter transfer phases, explicitly encoded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage : risc_bus_pkg
`default_nettype wire

// File: rtl/risc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : risc_rr_arb2
// Description : Two-way round-robin selector. A lone requester wins; on a tie
//               the master that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    // Pick the winner from the request pair and the previous grant
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = 1'b0;
        if (i_req0 && i_req1) begin
            o_grant = ~i_last_grant;
        end else if (i_req1) begin
            o_grant = 1'b1;
        end
    end

endmodule : risc_rr_arb2
`default_nettype wire

// File: rtl/risc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : risc_bus_arbiter
// Description : Round-robin arbiter between a CPU (m0) and a loader (m1) onto
//               a single registered slave bus, with access timeout and a
//               sticky stop flag raised by a write to STOP_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_bus_arbiter
    import risc_bus_pkg::*;
#(
    parameter logic [7:0] STOP_ADDR = c_STOP_ADDR_DEF,
    parameter int         TIMEOUT   = c_TIMEOUT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    // master 0 (CPU)
    input  logic                 i_m0_req,
    input  logic                 i_m0_write,
    input  logic [c_BUS_W-1:0]   i_m0_address,
    input  logic [c_BUS_W-1:0]   i_m0_data,
    output logic                 o_m0_ready,
    output logic [c_BUS_W-1:0]   o_m0_rdata,
    output logic                 o_m0_err,
    // master 1 (loader)
    input  logic                 i_m1_req,
    input  logic                 i_m1_write,
    input  logic [c_BUS_W-1:0]   i_m1_address,
    input  logic [c_BUS_W-1:0]   i_m1_data,
    output logic                 o_m1_ready,
    output logic [c_BUS_W-1:0]   o_m1_rdata,
    output logic                 o_m1_err,
    // slave bus
    output logic [c_BUS_W-1:0]   o_bus_address,
    output logic [c_BUS_W-1:0]   o_bus_data,
    output logic                 o_bus_read,
    output logic                 o_bus_write,
    input  logic [c_BUS_W-1:0]   i_bus_data,
    input  logic                 i_bus_ready,
    // stop reporting
    output logic                 o_stop,
    output logic [c_BUS_W-1:0]   o_stop_code
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_last_grant;
    logic                 r_gnt;
    logic                 r_write;
    logic [c_BUS_W-1:0]   r_addr;
    logic [c_BUS_W-1:0]   r_data;
    logic                 r_bus_read;
    logic                 r_bus_write;
    logic                 r_m0_ready;
    logic                 r_m1_ready;
    logic                 r_m0_err;
    logic                 r_m1_err;
    logic [c_BUS_W-1:0]   r_m0_rdata;
    logic [c_BUS_W-1:0]   r_m1_rdata;
    logic                 r_stop;
    logic [c_BUS_W-1:0]   r_stop_code;

    logic                 w_arb_valid;
    logic                 w_arb_grant;
    logic                 w_start;
    logic                 w_ready_hit;
    logic                 w_timeout;
    logic                 w_done;
    logic                 w_sel_write;
    logic [c_BUS_W-1:0]   w_sel_addr;
    logic [c_BUS_W-1:0]   w_sel_data;
    logic                 w_rdata_we;
    logic [c_BUS_W-1:0]   w_rdata_val;
    logic                 w_stop_set;

    risc_rr_arb2 u_rr (
        .i_req0       (i_m0_req),
        .i_req1       (i_m1_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_arb_valid),
        .o_grant      (w_arb_grant)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = ACCESS;
            ACCESS:  if (w_done)  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Decode of grant/complete events and the values they load
    always_comb begin
        w_start     = (r_state == IDLE) && w_arb_valid && !r_stop;
        // bus ready takes priority over an expiring counter
        w_ready_hit = (r_state == ACCESS) && i_bus_ready;
        w_timeout   = (r_state == ACCESS) && !i_bus_ready && (r_cnt == c_CNT_LAST);
        w_done      = w_ready_hit || w_timeout;
        w_sel_write = w_arb_grant ? i_m1_write   : i_m0_write;
        w_sel_addr  = w_arb_grant ? i_m1_address : i_m0_address;
        w_sel_data  = w_arb_grant ? i_m1_data    : i_m0_data;
        // a successful write leaves the master's read data untouched
        w_rdata_we  = w_timeout || (w_ready_hit && !r_write);
        w_rdata_val = w_timeout ? c_ERR_RDATA : i_bus_data;
        w_stop_set  = w_ready_hit && r_write && (r_addr == STOP_ADDR);
    end

    // Transfer control: grant latch, bus strobes and access counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
        end else if (w_start) begin
            r_cnt        <= '0;
            r_last_grant <= w_arb_grant;
            r_gnt        <= w_arb_grant;
            r_write      <= w_sel_write;
            r_addr       <= w_sel_addr;
            r_data       <= w_sel_data;
            r_bus_read   <= !w_sel_write;
            r_bus_write  <= w_sel_write;
        end else if (r_state == ACCESS) begin
            if (w_done) begin
                r_bus_read  <= 1'b0;
                r_bus_write <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Completion strobes, per-master read data and sticky stop flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_stop      <= 1'b0;
            r_stop_code <= '0;
        end else begin
            r_m0_ready <= w_done && !r_gnt;
            r_m1_ready <= w_done &&  r_gnt;
            r_m0_err   <= w_timeout && !r_gnt;
            r_m1_err   <= w_timeout &&  r_gnt;
            if (w_rdata_we && !r_gnt) r_m0_rdata <= w_rdata_val;
            if (w_rdata_we &&  r_gnt) r_m1_rdata <= w_rdata_val;
            if (w_stop_set) begin
                r_stop      <= 1'b1;
                r_stop_code <= r_data;
            end
        end
    end

    assign o_bus_address = r_addr;
    assign o_bus_data    = r_data;
    assign o_bus_read    = r_bus_read;
    assign o_bus_write   = r_bus_write;
    assign o_m0_ready    = r_m0_ready;
    assign o_m1_ready    = r_m1_ready;
    assign o_m0_err      = r_m0_err;
    assign o_m1_err      = r_m1_err;
    assign o_m0_rdata    = r_m0_rdata;
    assign o_m1_rdata    = r_m1_rdata;
    assign o_stop        = r_stop;
    assign o_stop_code   = r_stop_code;

endmodule : risc_bus_arbiter
`default_nettype wire
